// File: rtl/alu_execute_controller.sv
`default_nettype none
// ============================================================================
// Module   : alu_execute_controller
// Purpose  : Sequences one ALU instruction at a time. It reads two operands
//            from an 8 x 16-bit register file and presents them to an external
//            registered ALU. It then writes the ALU result and six status flags
//            back into the register file and the flag register.
//            Each instruction takes three cycles: ISSUE, WRITE, then the done
//            cycle, which is back in IDLE.
// Ports    : clk, reset (sync, active-high)
//            instr_valid/instr_ready/instr : instruction handshake
//            ld_en/ld_addr/ld_data        : register preload (IDLE only)
//            dbg_addr/dbg_data            : combinational register read
//            alu_*  (out)                 : registered operands/controls to ALU
//            alu_*  (in)                  : ALU result and status
//            flags                        : {gt, eq, parity, zero, sign, carry}
//            done                         : one-cycle completion pulse
// Revision : 1.0 - initial release
// ============================================================================
module alu_execute_controller #(
  parameter int NREGS = 8  // register file depth; addressing is fixed at 3 bits
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [15:0] instr,
  input  logic        ld_en,
  input  logic [2:0]  ld_addr,
  input  logic [15:0] ld_data,
  input  logic [2:0]  dbg_addr,
  output logic [15:0] dbg_data,
  output logic        alu_enable,
  output logic [15:0] alu_in1,
  output logic [15:0] alu_in2,
  output logic        alu_carry_in,
  output logic        alu_mode,
  output logic [3:0]  alu_func,
  input  logic [15:0] alu_result,
  input  logic        alu_carry_out,
  input  logic        alu_sign,
  input  logic        alu_zero,
  input  logic        alu_parity,
  input  logic        alu_equal,
  input  logic        alu_greater_than,
  output logic [5:0]  flags,
  output logic        done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WRITE = 2'd2
  } state_t;

  state_t      state;
  logic [15:0] regs [NREGS];
  logic [2:0]  rd;

  // Instruction fields
  logic        f_mode;
  logic [3:0]  f_func;
  logic [2:0]  f_rd;
  logic [2:0]  f_rs1;
  logic [2:0]  f_rs2;
  logic        f_use_carry;
  logic        unused_reserved;

  assign f_mode          = instr[15];
  assign f_func          = instr[14:11];
  assign f_rd            = instr[10:8];
  assign f_rs1           = instr[7:5];
  assign f_rs2           = instr[4:2];
  assign f_use_carry     = instr[1];
  assign unused_reserved = instr[0];

  // A preload takes the IDLE slot, so the instruction waits one cycle.
  assign instr_ready = (state == IDLE) && !ld_en;
  assign dbg_data    = regs[dbg_addr];

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      for (int i = 0; i < NREGS; i++) regs[i] <= 16'h0000;
      flags        <= 6'd0;
      done         <= 1'b0;
      alu_enable   <= 1'b0;
      alu_in1      <= 16'h0000;
      alu_in2      <= 16'h0000;
      alu_carry_in <= 1'b0;
      alu_mode     <= 1'b0;
      alu_func     <= 4'd0;
      rd           <= 3'd0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (ld_en) begin
            regs[ld_addr] <= ld_data;
          end else if (instr_valid) begin
            // Operands come from the register state before this edge, so
            // rd may alias rs1/rs2 without hazard.
            alu_in1      <= regs[f_rs1];
            alu_in2      <= regs[f_rs2];
            alu_mode     <= f_mode;
            alu_func     <= f_func;
            alu_carry_in <= f_use_carry & flags[0];
            rd           <= f_rd;
            alu_enable   <= 1'b1;
            state        <= ISSUE;
          end
        end
        ISSUE: begin
          // The ALU captures its inputs at the end of this cycle.
          alu_enable <= 1'b0;
          state      <= WRITE;
        end
        WRITE: begin
          regs[rd] <= alu_result;
          flags    <= {alu_greater_than, alu_equal, alu_parity,
                       alu_zero, alu_sign, alu_carry_out};
          done     <= 1'b1;
          state    <= IDLE;
        end
        default: begin
          state      <= IDLE;
          alu_enable <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_execute_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_execute_controller
// Purpose  : Self-checking bench for alu_execute_controller. It includes a
//            registered ALU model, a behavioural reference model checked on
//            every cycle, directed scenarios with literal expectations, and
//            randomized stimulus.
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_execute_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        instr_valid = 1'b0;
  logic        instr_ready;
  logic [15:0] instr = 16'h0;
  logic        ld_en = 1'b0;
  logic [2:0]  ld_addr = 3'd0;
  logic [15:0] ld_data = 16'h0;
  logic [2:0]  dbg_addr = 3'd0;
  logic [15:0] dbg_data;
  logic        alu_enable;
  logic [15:0] alu_in1, alu_in2;
  logic        alu_carry_in, alu_mode;
  logic [3:0]  alu_func;
  logic [15:0] alu_result = 16'h0;
  logic [5:0]  alu_st = 6'd0;  // {gt, eq, parity, zero, sign, carry}
  logic [5:0]  flags;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_execute_controller #(.NREGS(8)) dut (
    .clk(clk), .reset(reset),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data),
    .alu_enable(alu_enable), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_carry_in(alu_carry_in), .alu_mode(alu_mode), .alu_func(alu_func),
    .alu_result(alu_result),
    .alu_carry_out(alu_st[0]), .alu_sign(alu_st[1]), .alu_zero(alu_st[2]),
    .alu_parity(alu_st[3]), .alu_equal(alu_st[4]), .alu_greater_than(alu_st[5]),
    .flags(flags), .done(done)
  );

  // ALU behaviour: mode1/func0 is a sign-magnitude add; other codes are
  // arbitrary, non-commutative functions so that swapped operands show up.
  function automatic logic [21:0] alu_fn(input logic [15:0] a, input logic [15:0] b,
                                          input logic cin, input logic mode,
                                          input logic [3:0] fn);
    logic [15:0] r;
    logic        c;
    logic [15:0] ma, mb;
    logic [16:0] s;
    r = 16'h0; c = 1'b0;
    ma = {1'b0, a[14:0]};
    mb = {1'b0, b[14:0]};
    if (mode && fn == 4'd0) begin
      if (a[15] == b[15]) begin
        s = {1'b0, ma} + {1'b0, mb} + {16'd0, cin};
        c = s[15];
        r = {a[15], s[14:0]};
      end else if (ma >= mb) begin
        s = {1'b0, ma - mb};
        r = (ma == mb) ? 16'h0000 : {a[15], s[14:0]};
      end else begin
        s = {1'b0, mb - ma};
        r = {b[15], s[14:0]};
      end
    end else if (mode) begin
      s = {1'b0, a} + {1'b0, b[7:0], b[15:8]} + {16'd0, cin} + {13'd0, fn};
      r = s[15:0];
      c = s[16];
    end else begin
      r = (a & ~b) ^ {4{fn}};
      c = a[15];
    end
    return {a > b, a == b, ^r, r == 16'h0, r[15], c, r};
  endfunction

  // Registered ALU: captures its inputs while enabled.
  always @(posedge clk)
    if (alu_enable)
      {alu_st, alu_result} <= alu_fn(alu_in1, alu_in2, alu_carry_in, alu_mode, alu_func);

  // ---------------- reference model ----------------
  int          cyc = 0;
  bit          started = 0;
  bit          busy = 0;
  int          acc_cyc = 0;
  logic [15:0] m_regs [8];
  logic [5:0]  m_flags = 6'd0;
  logic [15:0] e_in1 = 16'h0, e_in2 = 16'h0;
  logic        e_cin = 1'b0, e_mode = 1'b0;
  logic [3:0]  e_func = 4'd0;
  logic [2:0]  e_rd = 3'd0;
  bit          e_done = 0;

  always @(posedge clk) begin
    logic [21:0] res;
    cyc++;
    started = 1;
    e_done  = 0;
    if (reset) begin
      foreach (m_regs[i]) m_regs[i] = 16'h0;
      m_flags = 6'd0; busy = 0;
      e_in1 = 16'h0; e_in2 = 16'h0; e_cin = 1'b0; e_mode = 1'b0; e_func = 4'd0;
    end else if (busy && cyc == acc_cyc + 2) begin
      res = alu_fn(e_in1, e_in2, e_cin, e_mode, e_func);
      m_regs[e_rd] = res[15:0];
      m_flags      = res[21:16];
      busy   = 0;
      e_done = 1;
    end else if (!busy) begin
      if (ld_en) m_regs[ld_addr] = ld_data;
      else if (instr_valid) begin
        e_in1  = m_regs[instr[7:5]];
        e_in2  = m_regs[instr[4:2]];
        e_mode = instr[15];
        e_func = instr[14:11];
        e_cin  = instr[1] & m_flags[0];
        e_rd   = instr[10:8];
        busy    = 1;
        acc_cyc = cyc;
      end
    end
  end

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare against the model.
  always @(negedge clk) begin
    if (started) begin
      chk("m_ready",  16'(instr_ready),  16'(!busy && !ld_en));
      chk("m_done",   16'(done),         16'(e_done));
      chk("m_enable", 16'(alu_enable),   16'(busy && cyc == acc_cyc));
      chk("m_in1",    alu_in1,           e_in1);
      chk("m_in2",    alu_in2,           e_in2);
      chk("m_cin",    16'(alu_carry_in), 16'(e_cin));
      chk("m_mode",   16'(alu_mode),     16'(e_mode));
      chk("m_func",   16'(alu_func),     16'(e_func));
      chk("m_flags",  16'(flags),        16'(m_flags));
      chk("m_dbg",    dbg_data,          m_regs[dbg_addr]);
    end
  end

  // ---------------- directed helpers ----------------
  function automatic logic [15:0] enc(input logic mode, input logic [3:0] fn, input logic [2:0] rd,
                                      input logic [2:0] rs1, input logic [2:0] rs2, input logic uc);
    return {mode, fn, rd, rs1, rs2, uc, 1'b0};
  endfunction

  task automatic preload(input logic [2:0] a, input logic [15:0] d);
    @(negedge clk); #1;
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(posedge clk); #1;
    ld_en = 1'b0;
  endtask

  task automatic peek(input logic [2:0] a, output logic [15:0] d);
    dbg_addr = a; #1;
    d = dbg_data;
  endtask

  task automatic do_reset();
    @(negedge clk); #1;
    reset = 1'b1; instr_valid = 1'b0; ld_en = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  // Issues one instruction from IDLE and returns in its done cycle.
  task automatic run_op(input logic [15:0] ins, input logic expect_cin);
    @(negedge clk); #1;
    instr = ins; instr_valid = 1'b1;
    @(posedge clk); #1;                 // E0
    instr_valid = 1'b0;
    chk("issue_enable", 16'(alu_enable), 16'h1);
    chk("issue_cin", 16'(alu_carry_in), 16'(expect_cin));
    @(posedge clk); #1;                 // E1
    chk("done_early", 16'(done), 16'h0);
    @(posedge clk); #1;                 // E2
    chk("done_pulse", 16'(done), 16'h1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [15:0] v;
    logic        rdy [9];
    int          acc;

    do_reset();
    chk("rst_ready", 16'(instr_ready), 16'h1);
    chk("rst_done", 16'(done), 16'h0);
    chk("rst_flags", 16'(flags), 16'h0);
    peek(3'd3, v); chk("rst_r3", v, 16'h0000);

    // Basic add: 7 + 6 into R3
    preload(3'd1, 16'h0007);
    preload(3'd2, 16'h0006);
    @(negedge clk); #1;
    instr = 16'h8328; instr_valid = 1'b1;
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("add_in1", alu_in1, 16'h0007);
    chk("add_in2", alu_in2, 16'h0006);
    chk("add_mode", 16'(alu_mode), 16'h1);
    chk("add_func", 16'(alu_func), 16'h0);
    repeat (2) @(posedge clk);
    #1 chk("add_done", 16'(done), 16'h1);
    peek(3'd3, v); chk("add_r3", v, 16'h000D);
    @(posedge clk); #1 chk("add_done_end", 16'(done), 16'h0);

    // -9 + 9 into R4 gives zero
    preload(3'd1, 16'h8009);
    preload(3'd2, 16'h0009);
    run_op(enc(1'b1, 4'h0, 3'd4, 3'd1, 3'd2, 1'b0), 1'b0);
    peek(3'd4, v); chk("neg_r4", v, 16'h0000);
    chk("neg_zero", 16'(flags[2]), 16'h1);

    // Carry chain: 0x7FFF + 1 overflows the magnitude
    preload(3'd1, 16'h7FFF);
    preload(3'd2, 16'h0001);
    run_op(enc(1'b1, 4'h0, 3'd6, 3'd1, 3'd2, 1'b0), 1'b0);
    chk("carry_flag", 16'(flags[0]), 16'h1);
    run_op(enc(1'b1, 4'h0, 3'd6, 3'd1, 3'd2, 1'b1), 1'b1);
    run_op(enc(1'b1, 4'h0, 3'd6, 3'd1, 3'd2, 1'b0), 1'b0);

    // Back-to-back throughput with instr_valid held high
    @(negedge clk); #1;
    instr = enc(1'b1, 4'h3, 3'd7, 3'd1, 3'd2, 1'b0); instr_valid = 1'b1;
    acc = 0;
    for (int i = 0; i < 9; i++) begin
      rdy[i] = instr_ready;
      if (instr_ready) acc++;
      @(posedge clk); #1;
    end
    instr_valid = 1'b0;
    for (int i = 0; i < 9; i++) chk("thru_ready", 16'(rdy[i]), 16'((i % 3) == 0));
    chk("thru_count", 16'(acc), 16'd3);
    repeat (2) @(posedge clk);          // finish third op
    // Preload has priority over instruction in the same IDLE cycle
    @(negedge clk); #1;
    ld_en = 1'b1; ld_addr = 3'd7; ld_data = 16'h1234; instr_valid = 1'b1;
    instr = enc(1'b0, 4'h1, 3'd0, 3'd7, 3'd7, 1'b0);
    #1 chk("prio_ready", 16'(instr_ready), 16'h0);
    @(posedge clk); #1;
    ld_en = 1'b0;
    peek(3'd7, v); chk("prio_load", v, 16'h1234);
    chk("prio_ready2", 16'(instr_ready), 16'h1);
    @(posedge clk); #1;
    instr_valid = 1'b0;
    chk("prio_accept", 16'(alu_enable), 16'h1);
    chk("prio_in1", alu_in1, 16'h1234);
    repeat (3) @(posedge clk);

    // Reset during WRITE aborts the op targeting R5
    preload(3'd5, 16'h5555);
    @(negedge clk); #1;
    instr = enc(1'b1, 4'h2, 3'd5, 3'd1, 3'd2, 1'b0); instr_valid = 1'b1;
    @(posedge clk); #1 instr_valid = 1'b0;   // E0
    @(posedge clk); #1 reset = 1'b1;         // now in WRITE
    @(posedge clk); #1 reset = 1'b0;
    chk("abort_done", 16'(done), 16'h0);
    chk("abort_ready", 16'(instr_ready), 16'h1);
    peek(3'd5, v); chk("abort_r5", v, 16'h0000);
    @(posedge clk); #1 chk("abort_done2", 16'(done), 16'h0);

    // Logical op writing back into its own source
    preload(3'd1, 16'hAB70);
    preload(3'd2, 16'hF086);
    run_op(enc(1'b0, 4'hF, 3'd1, 3'd1, 3'd2, 1'b0), 1'b0);
    peek(3'd1, v); chk("logic_r1", v, 16'hF48F);

    // Randomized traffic, checked every cycle against the model
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk); #1;
      reset       = ($urandom_range(0, 79) == 0);
      ld_en       = ($urandom_range(0, 3) == 0);
      ld_addr     = 3'($urandom);
      ld_data     = ($urandom_range(0, 3) == 0) ? {1'b0, 15'h7FF0 + 15'($urandom_range(0, 31))}
                                                : 16'($urandom);
      instr_valid = ($urandom_range(0, 2) != 0);
      instr       = 16'($urandom);
      if ($urandom_range(0, 1) == 1) instr[15:11] = 5'b10000;
      dbg_addr    = 3'($urandom);
    end
    @(negedge clk); #1;
    reset = 1'b0; instr_valid = 1'b0; ld_en = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    #1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_execute_controller.md
ALU_EXECUTE_CONTROLLER -- requirements
Module: alu_execute_controller

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on the rising edge.
REQ-002 SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 SHALL have ports instr_valid (input, 1) and instr_ready (output, 1): instruction handshake; transfer occurs when both are high at a rising edge.
REQ-004 SHALL have port instr, input, 16 bits, with this encoding:
- [15] mode
- [14:11] func
- [10:8] rd
- [7:5] rs1
- [4:2] rs2
- [1] use_carry
- [0] reserved, ignored.
REQ-005 SHALL have ports ld_en (input, 1), ld_addr (input, 3) and ld_data (input, 16): register preload port.
REQ-006 SHALL have ports dbg_addr (input, 3) and dbg_data (output, 16): combinational register read.
REQ-007 SHALL have these ports toward the ALU: alu_enable (output, 1), alu_in1 (output, 16), alu_in2 (output, 16), alu_carry_in (output, 1), alu_mode (output, 1) and alu_func (output, 4).
REQ-008 SHALL have these ports from the ALU: alu_result (input, 16) and alu_carry_out, alu_sign, alu_zero, alu_parity, alu_equal, alu_greater_than (inputs, 1 bit each).
REQ-009 SHALL have port flags, output, 6 bits, with bit order {greater_than, equal, parity, zero, sign, carry}, bit 0 = carry.
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have parameter NREGS, default 8: register file depth; fixed, not configurable beyond 8.

Function
REQ-012 SHALL contain an 8 x 16-bit register file and a 6-bit flag register.
REQ-013 SHALL implement FSM states IDLE, ISSUE, WRITE; transitions:
- IDLE -> ISSUE on accepted instr
- ISSUE -> WRITE unconditionally
- WRITE -> IDLE unconditionally.
REQ-014 SHALL drive instr_ready = 1 only in IDLE with ld_en = 0; a preload has priority over an instruction in the same cycle.
REQ-015 SHALL, at acceptance edge E0, register the following; these values SHALL hold stable until the next accepted instruction:
- alu_in1 = R[rs1], alu_in2 = R[rs2]
- alu_mode = instr[15], alu_func = instr[14:11]
- alu_carry_in = use_carry ? flags[0] : 0
- rd.
REQ-016 SHALL assert alu_enable only during the ISSUE cycle (E0 to E1); the ALU registers its outputs at E1.
REQ-017 SHALL, at edge E2 (leaving WRITE), write alu_result into R[rd] and load flags from the six ALU status inputs.
REQ-018 SHALL assert done high for exactly the cycle following E2; that cycle is IDLE, so a new instruction may be accepted at E3.
REQ-019 SHALL give a latency of 3 cycles from acceptance to done and a maximum throughput of 1 instruction per 3 cycles.
REQ-020 SHALL write ld_data into R[ld_addr] at the edge when ld_en = 1 and state = IDLE; ld_en outside IDLE SHALL be ignored.
REQ-021 SHALL read operands from register state before the acceptance edge; rd = rs1 or rs2 is legal and writes back at E2.
REQ-022 SHALL leave the register file and flags unchanged by instr_valid outside IDLE, and SHALL not queue that instruction.
REQ-023 SHALL not interpret func/mode; all 32 mode/func codes SHALL pass through unchanged.
REQ-024 SHALL drive dbg_data = R[dbg_addr] combinationally, reflecting writes from the cycle after the write edge.

Reset
REQ-025 SHALL, while reset = 1 at a rising edge, set the following and assert instr_ready again the cycle after reset deasserts:
- state = IDLE
- all registers = 0x0000, flags = 0
- done = 0, alu_enable = 0
- alu_in1 = alu_in2 = 0, alu_carry_in = 0, alu_mode = 0, alu_func = 0.
REQ-026 SHALL give reset priority over ld_en, instr_valid and writeback; reset in ISSUE or WRITE SHALL abort with no register or flag write and no done pulse.

Verification
REQ-027 SHALL pass: preload R1 = 0x0007, R2 = 0x0006; instr 0x8328 (add, rd=3, rs1=1, rs2=2) -> ISSUE shows alu_in1 = 0x0007, alu_in2 = 0x0006, alu_mode = 1, alu_func = 0; with ALU model R3 = 0x000D, done exactly 3 cycles after acceptance.
REQ-028 SHALL pass: R1 = 0x8009 (-9), R2 = 0x0009, add into R4 -> R4 = 0x0000, flags[2] (zero) = 1.
REQ-029 SHALL pass: flags[0] = 1 from a prior op; next instr with use_carry = 1 -> alu_carry_in = 1 during ISSUE; with use_carry = 0 -> alu_carry_in = 0.
REQ-030 SHALL pass: instr_valid held high continuously -> instr_ready pattern 1,0,0,1,... and exactly one acceptance per 3 cycles; ld_en with instr_valid in IDLE -> load occurs, instruction accepted next cycle.
REQ-031 SHALL pass: reset asserted in WRITE of an op targeting R5 -> R5 = 0x0000, no done pulse, instr_ready = 1 after reset release.
REQ-032 SHALL pass: logical op (mode = 0, func = 4'hf) on R1 = 0xAB70, R2 = 0xF086 into R1 -> R1 updated to ALU result at E2; dbg_addr = 1 shows new value in done cycle.
